// File: rtl/conv_line_buffer.sv
// rtl/conv_line_buffer.sv - raster-to-column line buffer and kernel load sequencer for the 3x3 conv stage
module conv_line_buffer #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int NB_COL     = $clog2(IMG_WIDTH),
    parameter int NB_ROW     = $clog2(IMG_HEIGHT)
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic        i_sof,
    input  logic [7:0]  i_pixel,
    input  logic        i_knl_start,
    input  logic        i_knl_valid,
    input  logic [23:0] i_knl_data,
    output logic [7:0]  o_data1,
    output logic [7:0]  o_data2,
    output logic [7:0]  o_data3,
    output logic        o_en_conv,
    output logic        o_load_knl,
    output logic        o_win_valid,
    output logic        o_eof,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_KNL    = 2'd1,
        S_FLUSH  = 2'd2,
        S_STREAM = 2'd3
    } state_t;

    localparam logic [NB_COL-1:0] COL_LAST = NB_COL'(IMG_WIDTH - 1);
    localparam logic [NB_ROW-1:0] ROW_LAST = NB_ROW'(IMG_HEIGHT - 1);
    localparam logic [NB_COL-1:0] COL_TWO  = NB_COL'(2);
    localparam logic [NB_ROW-1:0] ROW_TWO  = NB_ROW'(2);

    // Line RAMs: lb_top holds row y-2, lb_mid holds row y-1. Never reset.
    logic [7:0] lb_top [IMG_WIDTH];
    logic [7:0] lb_mid [IMG_WIDTH];

    state_t            state_q;
    logic [1:0]        beat_q;
    logic [NB_COL-1:0] col_q, col_d;
    logic [NB_ROW-1:0] row_q, row_d;
    logic [7:0]        data1_q, data2_q, data3_q;
    logic              en_conv_q, load_knl_q, win_valid_q, eof_q, busy_q;

    logic              pix_accept;
    logic              pix_last;
    logic              win_d;
    logic [NB_COL-1:0] pix_col;
    logic [NB_ROW-1:0] pix_row;
    logic [7:0]        rd_top, rd_mid;

    // Position of the pixel being accepted this cycle; an SOF always forces (0,0).
    always_comb begin
        pix_accept = 1'b0;
        if (i_valid) begin
            if (state_q == S_STREAM)
                pix_accept = 1'b1;
            else if (state_q == S_IDLE && i_sof && !i_knl_start)
                pix_accept = 1'b1;
        end
        pix_col  = i_sof ? '0 : col_q;
        pix_row  = i_sof ? '0 : row_q;
        rd_top   = lb_top[pix_col];
        rd_mid   = lb_mid[pix_col];
        pix_last = (pix_col == COL_LAST) && (pix_row == ROW_LAST);
        win_d    = (pix_row >= ROW_TWO) && (pix_col >= COL_TWO);
        col_d    = pix_col + NB_COL'(1);
        row_d    = pix_row;
        if (pix_col == COL_LAST) begin
            col_d = '0;
            row_d = pix_row + NB_ROW'(1);
        end
        if (pix_last) begin
            col_d = '0;
            row_d = '0;
        end
    end

    // Shift the column down the line RAMs on every accepted pixel.
    always_ff @(posedge clk) begin
        if (pix_accept && !i_rst) begin
            lb_top[pix_col] <= rd_mid;
            lb_mid[pix_col] <= i_pixel;
        end
    end

    // Control FSM with registered outputs; strobes default low every cycle.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            col_q       <= '0;
            row_q       <= '0;
            data1_q     <= '0;
            data2_q     <= '0;
            data3_q     <= '0;
            en_conv_q   <= 1'b0;
            load_knl_q  <= 1'b0;
            win_valid_q <= 1'b0;
            eof_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            en_conv_q   <= 1'b0;
            load_knl_q  <= 1'b0;
            win_valid_q <= 1'b0;
            eof_q       <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (i_knl_start) begin
                        state_q <= S_KNL;
                        beat_q  <= '0;
                        busy_q  <= 1'b1;
                    end else if (pix_accept) begin
                        data1_q     <= rd_top;
                        data2_q     <= rd_mid;
                        data3_q     <= i_pixel;
                        en_conv_q   <= 1'b1;
                        win_valid_q <= win_d;
                        col_q       <= col_d;
                        row_q       <= row_d;
                        state_q     <= S_STREAM;
                        busy_q      <= 1'b1;
                    end
                end
                S_KNL: begin
                    if (i_knl_valid) begin
                        data1_q    <= i_knl_data[7:0];
                        data2_q    <= i_knl_data[15:8];
                        data3_q    <= i_knl_data[23:16];
                        load_knl_q <= 1'b1;
                        if (beat_q == 2'd2) begin
                            beat_q  <= '0;
                            state_q <= S_FLUSH;
                        end else begin
                            beat_q <= beat_q + 2'd1;
                        end
                    end
                end
                S_FLUSH: begin
                    // Extra zero strobe wraps the downstream load counter back to 0.
                    data1_q    <= '0;
                    data2_q    <= '0;
                    data3_q    <= '0;
                    load_knl_q <= 1'b1;
                    state_q    <= S_IDLE;
                    busy_q     <= 1'b0;
                end
                S_STREAM: begin
                    if (pix_accept) begin
                        data1_q     <= rd_top;
                        data2_q     <= rd_mid;
                        data3_q     <= i_pixel;
                        en_conv_q   <= 1'b1;
                        win_valid_q <= win_d;
                        eof_q       <= pix_last;
                        col_q       <= col_d;
                        row_q       <= row_d;
                        if (pix_last) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_data1     = data1_q;
    assign o_data2     = data2_q;
    assign o_data3     = data3_q;
    assign o_en_conv   = en_conv_q;
    assign o_load_knl  = load_knl_q;
    assign o_win_valid = win_valid_q;
    assign o_eof       = eof_q;
    assign o_busy      = busy_q;

endmodule
